// File: rtl/dmem_io_bridge_pkg.sv
// Shared constants for the dmem / I/O bridge: region base, register offsets and STATUS layout.
package dmem_io_bridge_pkg;

    localparam logic [11:0] IO_BASE    = 12'hFF0;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned FIFO_AW    = 3;

    localparam logic [11:0] OFS_LED    = 12'd0;
    localparam logic [11:0] OFS_TX     = 12'd1;
    localparam logic [11:0] OFS_STATUS = 12'd2;
    localparam logic [11:0] OFS_CYCLES = 12'd3;

    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_OVF   = 2;
    localparam int unsigned ST_COUNT = 4;

    function automatic logic [31:0] pack_status(logic [3:0] count, logic ovf, logic full,
                                                logic empty);
        logic [31:0] s;
        s                = '0;
        s[ST_COUNT +: 4] = count;
        s[ST_OVF]        = ovf;
        s[ST_FULL]       = full;
        s[ST_EMPTY]      = empty;
        return s;
    endfunction

endpackage

// File: rtl/dmem_io_bridge_if.sv
// Processor / dmem / LED / UART-TX signal bundle seen by the bridge (slave) and its environment.
interface dmem_io_bridge_if;

    logic [11:0] proc_addr;
    logic [31:0] proc_wdata;
    logic        proc_wren;
    logic [31:0] proc_rdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic [15:0] led;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport slave (
        input  proc_addr, proc_wdata, proc_wren, mem_q, tx_ready,
        output proc_rdata, mem_addr, mem_wdata, mem_wren, led, tx_valid, tx_data
    );

    modport master (
        output proc_addr, proc_wdata, proc_wren, mem_q, tx_ready,
        input  proc_rdata, mem_addr, mem_wdata, mem_wren, led, tx_valid, tx_data
    );

endinterface

// File: rtl/dmem_io_bridge_io_tx_fifo.sv
// Circular byte FIFO for UART TX with sticky overflow flag; Depth must be a power of two.
module io_tx_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Aw    = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [7:0]    push_data_i,
    input  logic          ready_i,
    input  logic          clr_ovf_i,
    output logic          valid_o,
    output logic [7:0]    data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [Aw:0]   count_o,
    output logic          ovf_o
);

    localparam logic [Aw:0]   DepthC   = (Aw + 1)'(Depth);
    localparam logic [Aw:0]   CountOne = (Aw + 1)'(1);
    localparam logic [Aw-1:0] PtrOne   = Aw'(1);

    logic [7:0]    storage_q [Depth];
    logic [Aw-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [Aw:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          pop, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DepthC);
    assign valid_o = ~empty_o;
    assign data_o  = storage_q[rd_ptr_q];
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

    // A pop frees a slot in the same cycle, so push-while-full succeeds when draining.
    assign pop     = valid_o & ready_i;
    assign push_ok = push_i & (~full_o | pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop)     rd_ptr_d = rd_ptr_q + PtrOne;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
        if (push_ok && !pop)      count_d = count_q + CountOne;
        else if (!push_ok && pop) count_d = count_q - CountOne;
        if (clr_ovf_i)         ovf_d = 1'b0;
        if (push_i && !push_ok) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) storage_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/dmem_io_bridge.sv
// Splits processor data accesses between dmem and a small I/O register block (LED, UART TX FIFO,
// status, cycle counter) without ever stalling the processor.
module dmem_io_bridge
    import dmem_io_bridge_pkg::*;
#(
    parameter logic [11:0] IoBase = IO_BASE
) (
    input  logic               clock,
    input  logic               reset,
    dmem_io_bridge_if.slave    io_bus
);

    logic        io_sel, io_wr;
    logic [11:0] ofs;
    logic        wr_led, wr_tx, wr_status, wr_cycles;
    logic [15:0] led_q, led_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] io_rdata;
    logic        fifo_full, fifo_empty, fifo_ovf;
    logic [FIFO_AW:0] fifo_count;

    assign io_sel    = (io_bus.proc_addr >= IoBase);
    assign ofs       = io_bus.proc_addr - IoBase;
    assign io_wr     = io_bus.proc_wren & io_sel;
    assign wr_led    = io_wr & (ofs == OFS_LED);
    assign wr_tx     = io_wr & (ofs == OFS_TX);
    assign wr_status = io_wr & (ofs == OFS_STATUS);
    assign wr_cycles = io_wr & (ofs == OFS_CYCLES);

    assign io_bus.mem_addr   = io_bus.proc_addr;
    assign io_bus.mem_wdata  = io_bus.proc_wdata;
    assign io_bus.mem_wren   = io_bus.proc_wren & ~io_sel;
    assign io_bus.proc_rdata = io_sel ? io_rdata : io_bus.mem_q;
    assign io_bus.led        = led_q;

    always_comb begin
        led_d = led_q;
        if (wr_led) led_d = io_bus.proc_wdata[15:0];
        cycles_d = wr_cycles ? io_bus.proc_wdata : cycles_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_q    <= '0;
            cycles_q <= '0;
        end else begin
            led_q    <= led_d;
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        io_rdata = '0;
        case (ofs)
            OFS_LED:    io_rdata = {16'b0, led_q};
            OFS_STATUS: io_rdata = pack_status(4'(fifo_count), fifo_ovf, fifo_full, fifo_empty);
            OFS_CYCLES: io_rdata = cycles_q;
            default:    io_rdata = '0;
        endcase
    end

    io_tx_fifo #(
        .Depth (FIFO_DEPTH),
        .Aw    (FIFO_AW)
    ) u_tx_fifo (
        .clk_i       (clock),
        .rst_ni      (reset),
        .push_i      (wr_tx),
        .push_data_i (io_bus.proc_wdata[7:0]),
        .ready_i     (io_bus.tx_ready),
        .clr_ovf_i   (wr_status & io_bus.proc_wdata[ST_OVF]),
        .valid_o     (io_bus.tx_valid),
        .data_o      (io_bus.tx_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .ovf_o       (fifo_ovf)
    );

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Directed self-checking bench for dmem_io_bridge: pass-through, LED, TX FIFO, CYCLES, reset.
module tb_dmem_io_bridge;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    dmem_io_bridge_if bus ();

    dmem_io_bridge dut (
        .clock  (clock),
        .reset  (reset),
        .io_bus (bus)
    );

    // Small dmem model: written on the rising edge, read combinationally.
    logic [31:0] dmem [64];
    always @(posedge clock) if (bus.mem_wren) dmem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    assign bus.mem_q = dmem[bus.mem_addr[5:0]];

    task automatic drive(input logic [11:0] addr, input logic [31:0] wdata, input logic wren);
        @(negedge clock);
        bus.proc_addr  = addr;
        bus.proc_wdata = wdata;
        bus.proc_wren  = wren;
        #1;
    endtask

    task automatic test_reset();
        bus.proc_addr  = 12'hFF3;
        bus.proc_wdata = '0;
        bus.proc_wren  = 1'b0;
        bus.tx_ready   = 1'b0;
        reset          = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_checks++;
        if (bus.proc_rdata !== 32'h0) begin
            n_errors++; $display("FAIL reset_cycles got %h want %h", bus.proc_rdata, 32'h0);
        end
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.led !== 16'h0) begin
            n_errors++; $display("FAIL reset_outputs got valid=%b led=%h want 0/0000",
                                 bus.tx_valid, bus.led);
        end
        reset = 1'b1;
        drive(12'hFF2, 32'h0, 1'b0);
        n_checks++;
        if (bus.proc_rdata !== 32'h1) begin
            n_errors++; $display("FAIL reset_status got %h want %h", bus.proc_rdata, 32'h1);
        end
    endtask

    task automatic test_passthrough();
        drive(12'h010, 32'hDEADBEEF, 1'b1);
        n_checks++;
        if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 12'h010 || bus.mem_wdata !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL pass_store got wren=%b addr=%h data=%h want 1/010/deadbeef",
                                 bus.mem_wren, bus.mem_addr, bus.mem_wdata);
        end
        drive(12'h010, 32'h0, 1'b0);
        n_checks++;
        if (bus.proc_rdata !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL pass_load got %h want deadbeef", bus.proc_rdata);
        end
        n_checks++;
        if (bus.led !== 16'h0) begin
            n_errors++; $display("FAIL pass_led got %h want 0000", bus.led);
        end
    endtask

    task automatic test_led();
        drive(12'hFF0, 32'h0001A5A5, 1'b1);
        n_checks++;
        if (bus.mem_wren !== 1'b0) begin
            n_errors++; $display("FAIL led_memwren got %b want 0", bus.mem_wren);
        end
        drive(12'hFF0, 32'h0, 1'b0);
        n_checks++;
        if (bus.led !== 16'hA5A5 || bus.proc_rdata !== 32'h0000A5A5) begin
            n_errors++; $display("FAIL led_read got led=%h rdata=%h want a5a5/0000a5a5",
                                 bus.led, bus.proc_rdata);
        end
        drive(12'hFF1, 32'h0, 1'b0);
        n_checks++;
        if (bus.proc_rdata !== 32'h0) begin
            n_errors++; $display("FAIL txdata_read got %h want 0", bus.proc_rdata);
        end
        drive(12'hFF8, 32'h12345678, 1'b1);
        n_checks++;
        if (bus.mem_wren !== 1'b0 || bus.proc_rdata !== 32'h0) begin
            n_errors++; $display("FAIL reserved got wren=%b rdata=%h want 0/0",
                                 bus.mem_wren, bus.proc_rdata);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [7:0] exp;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive(12'hFF1, 32'h41 + i, 1'b1);
        drive(12'hFF2, 32'h0, 1'b0);
        n_checks++;
        if (bus.proc_rdata !== 32'h82 || bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h41) begin
            n_errors++; $display("FAIL fifo_full got st=%h v=%b d=%h want 82/1/41",
                                 bus.proc_rdata, bus.tx_valid, bus.tx_data);
        end
        drive(12'hFF1, 32'h49, 1'b1);
        drive(12'hFF2, 32'h0, 1'b0);
        n_checks++;
        if (bus.proc_rdata !== 32'h86) begin
            n_errors++; $display("FAIL fifo_ovf got %h want 86", bus.proc_rdata);
        end
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = 8'h41 + 8'(i);
            n_checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp) begin
                n_errors++; $display("FAIL drain_%0d got v=%b d=%h want 1/%h",
                                     i, bus.tx_valid, bus.tx_data, exp);
            end
            @(negedge clock);
            #1;
        end
        bus.tx_ready = 1'b0;
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.proc_rdata !== 32'h05) begin
            n_errors++; $display("FAIL drained got v=%b st=%h want 0/05",
                                 bus.tx_valid, bus.proc_rdata);
        end
        drive(12'hFF2, 32'h4, 1'b1);
        drive(12'hFF2, 32'h0, 1'b0);
        n_checks++;
        if (bus.proc_rdata !== 32'h01) begin
            n_errors++; $display("FAIL ovf_clear got %h want 01", bus.proc_rdata);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) drive(12'hFF1, 32'h50 + i, 1'b1);
        drive(12'hFF1, 32'h58, 1'b1);
        bus.tx_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.tx_ready  = 1'b0;
        bus.proc_wren = 1'b0;
        bus.proc_addr = 12'hFF2;
        #1;
        n_checks++;
        if (bus.proc_rdata !== 32'h82 || bus.tx_data !== 8'h51) begin
            n_errors++; $display("FAIL full_pushpop got st=%h d=%h want 82/51",
                                 bus.proc_rdata, bus.tx_data);
        end
        @(negedge clock);
        #1;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = 8'h51 + 8'(i);
            n_checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp) begin
                n_errors++; $display("FAIL pp_drain_%0d got v=%b d=%h want 1/%h",
                                     i, bus.tx_valid, bus.tx_data, exp);
            end
            @(negedge clock);
            #1;
        end
        bus.tx_ready = 1'b0;
        n_checks++;
        if (bus.proc_rdata !== 32'h01) begin
            n_errors++; $display("FAIL pp_empty got %h want 01", bus.proc_rdata);
        end
    endtask

    task automatic test_cycles();
        drive(12'hFF3, 32'hFFFFFFFE, 1'b1);
        drive(12'hFF3, 32'h0, 1'b0);
        n_checks++;
        if (bus.proc_rdata !== 32'hFFFFFFFE) begin
            n_errors++; $display("FAIL cycles_load got %h want fffffffe", bus.proc_rdata);
        end
        @(negedge clock);
        #1;
        n_checks++;
        if (bus.proc_rdata !== 32'hFFFFFFFF) begin
            n_errors++; $display("FAIL cycles_inc got %h want ffffffff", bus.proc_rdata);
        end
        @(negedge clock);
        #1;
        n_checks++;
        if (bus.proc_rdata !== 32'h0) begin
            n_errors++; $display("FAIL cycles_wrap got %h want 0", bus.proc_rdata);
        end
    endtask

    task automatic test_reset_mid_drain();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive(12'hFF1, 32'h61 + i, 1'b1);
        drive(12'hFF2, 32'h0, 1'b0);
        bus.tx_ready = 1'b1;
        @(negedge clock);
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.led !== 16'h0) begin
            n_errors++; $display("FAIL async_reset got v=%b led=%h want 0/0000",
                                 bus.tx_valid, bus.led);
        end
        bus.proc_addr  = 12'h020;
        bus.proc_wdata = 32'hCAFEF00D;
        bus.proc_wren  = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_wren !== 1'b1 || bus.mem_wdata !== 32'hCAFEF00D) begin
            n_errors++; $display("FAIL reset_passthru got wren=%b data=%h want 1/cafef00d",
                                 bus.mem_wren, bus.mem_wdata);
        end
        @(negedge clock);
        bus.proc_wren = 1'b0;
        bus.tx_ready  = 1'b0;
        reset         = 1'b1;
        drive(12'hFF2, 32'h0, 1'b0);
        n_checks++;
        if (bus.proc_rdata !== 32'h01 || bus.led !== 16'h0) begin
            n_errors++; $display("FAIL post_reset got st=%h led=%h want 01/0000",
                                 bus.proc_rdata, bus.led);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_led();
        test_fifo_overflow();
        test_full_push_pop();
        test_cycles();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
